// File: rtl/ddr3_cmd_responder_if.sv
// ============================================================================
// Module   : ddr3_cmd_responder_if
// Purpose  : Command, write-data and read-data bundle between a DDR3 command
//            master and the ddr3_cmd_responder memory stand-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ddr3_cmd_responder_if #(
    parameter int AWidth = 28,
    parameter int DWidth = 512,
    parameter int CWidth = 3
);
    logic [AWidth-1:0] CommandAddress;
    logic [CWidth-1:0] Command;
    logic              CommandValid;
    logic              CommandReady;
    logic [DWidth-1:0] DataIn;
    logic              DataInValid;
    logic              DataInReady;
    logic [DWidth-1:0] DataOut;
    logic              DataOutValid;
    logic              DataOutReady;
    logic [31:0]       ReadCount;
    logic [31:0]       WriteCount;
    logic [15:0]       BadCmdCount;

    modport master (
        output CommandAddress, Command, CommandValid, DataIn, DataInValid, DataOutReady,
        input  CommandReady, DataInReady, DataOut, DataOutValid,
               ReadCount, WriteCount, BadCmdCount
    );

    modport slave (
        input  CommandAddress, Command, CommandValid, DataIn, DataInValid, DataOutReady,
        output CommandReady, DataInReady, DataOut, DataOutValid,
               ReadCount, WriteCount, BadCmdCount
    );
endinterface

`default_nettype wire

// File: rtl/ddr3_cmd_responder.sv
// ============================================================================
// Module   : ddr3_cmd_responder
// Purpose  : Deterministic DDR3 memory stand-in: stores write bursts and
//            returns read bursts after a fixed latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr3_cmd_responder #(
    parameter int                AWidth      = 28,
    parameter int                DWidth      = 512,
    parameter int                CWidth      = 3,
    parameter int                MemDepthLog = 10,
    parameter int                ReadLatency = 8,
    parameter logic [CWidth-1:0] CmdRead     = 3'b001,
    parameter logic [CWidth-1:0] CmdWrite    = 3'b000
) (
    input  wire logic           Clock,
    input  wire logic           Reset,
    ddr3_cmd_responder_if.slave bus
);

    localparam int c_depth = 1 << MemDepthLog;
    localparam int c_lat_w = (ReadLatency > 2) ? $clog2(ReadLatency) : 1;

    localparam logic [1:0] ST_Idle   = 2'd0;
    localparam logic [1:0] ST_WrData = 2'd1;
    localparam logic [1:0] ST_RdWait = 2'd2;
    localparam logic [1:0] ST_RdOut  = 2'd3;

    logic [1:0]             r_state;
    logic                   r_alive;
    logic [MemDepthLog-1:0] r_idx;
    logic [c_lat_w-1:0]     r_lat_cnt;
    logic [DWidth-1:0]      r_data_out;
    logic [c_depth-1:0]     r_written;
    logic [31:0]            r_read_cnt;
    logic [31:0]            r_write_cnt;
    logic [15:0]            r_bad_cnt;
    logic [DWidth-1:0]      r_mem [c_depth];

    logic                   w_cmd_fire;
    logic                   w_wr_fire;
    logic [MemDepthLog-1:0] w_cmd_idx;
    logic                   w_unused;

    // Address bits below the burst and above the array depth alias silently.
    assign w_cmd_idx  = bus.CommandAddress[MemDepthLog+2:3];
    assign w_unused   = ^{bus.CommandAddress[AWidth-1:MemDepthLog+3], bus.CommandAddress[2:0]};

    assign w_cmd_fire = bus.CommandValid && bus.CommandReady;
    assign w_wr_fire  = bus.DataInValid && (r_state == ST_WrData);

    // r_alive keeps CommandReady low until the first edge after reset release.
    assign bus.CommandReady = r_alive && (r_state == ST_Idle);
    assign bus.DataInReady  = (r_state == ST_WrData);
    assign bus.DataOutValid = (r_state == ST_RdOut);
    assign bus.DataOut      = r_data_out;
    assign bus.ReadCount    = r_read_cnt;
    assign bus.WriteCount   = r_write_cnt;
    assign bus.BadCmdCount  = r_bad_cnt;

    always_ff @(posedge Clock) begin
        if (w_wr_fire) begin
            r_mem[r_idx] <= bus.DataIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state     <= ST_Idle;
            r_alive     <= 1'b0;
            r_idx       <= '0;
            r_lat_cnt   <= '0;
            r_data_out  <= '0;
            r_written   <= '0;
            r_read_cnt  <= 32'd0;
            r_write_cnt <= 32'd0;
            r_bad_cnt   <= 16'd0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                ST_Idle: begin
                    if (w_cmd_fire) begin
                        if (bus.Command == CmdWrite) begin
                            r_idx   <= w_cmd_idx;
                            r_state <= ST_WrData;
                        end else if (bus.Command == CmdRead) begin
                            r_idx      <= w_cmd_idx;
                            r_lat_cnt  <= c_lat_w'(ReadLatency - 1);
                            r_read_cnt <= r_read_cnt + 32'd1;
                            r_state    <= ST_RdWait;
                        end else if (r_bad_cnt != 16'hFFFF) begin
                            r_bad_cnt <= r_bad_cnt + 16'd1;
                        end
                    end
                end
                ST_WrData: begin
                    if (w_wr_fire) begin
                        r_written[r_idx] <= 1'b1;
                        r_write_cnt      <= r_write_cnt + 32'd1;
                        r_state          <= ST_Idle;
                    end
                end
                ST_RdWait: begin
                    if (r_lat_cnt == '0) begin
                        // Never-written entries read as zero, not stale array contents.
                        r_data_out <= r_written[r_idx] ? r_mem[r_idx] : '0;
                        r_state    <= ST_RdOut;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 1'b1;
                    end
                end
                ST_RdOut: begin
                    if (bus.DataOutReady) begin
                        r_data_out <= '0;
                        r_state    <= ST_Idle;
                    end
                end
                default: r_state <= ST_Idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ddr3_cmd_responder.sv
// ============================================================================
// Module   : tb_ddr3_cmd_responder
// Purpose  : Scoreboard bench for ddr3_cmd_responder (directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr3_cmd_responder;

    localparam logic [2:0] CMD_RD  = 3'b001;
    localparam logic [2:0] CMD_WR  = 3'b000;
    localparam logic [2:0] CMD_BAD = 3'b101;

    typedef struct {
        logic [511:0] data;
        int           due;
    } exp_t;

    logic Clock;
    logic Reset;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    logic         in_burst = 1'b0;
    logic [511:0] held     = '0;

    ddr3_cmd_responder_if #(.AWidth(28), .DWidth(512), .CWidth(3)) bus ();

    ddr3_cmd_responder #(
        .AWidth(28), .DWidth(512), .CWidth(3), .MemDepthLog(10),
        .ReadLatency(8), .CmdRead(CMD_RD), .CmdWrite(CMD_WR)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .bus  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation on the first cycle of each read burst.
    always @(negedge Clock) begin
        exp_t e;
        if (bus.DataOutValid) begin
            if (!in_burst) begin
                in_burst = 1'b1;
                held     = bus.DataOut;
                if (sb.size() == 0) begin
                    check("unexpected_valid", {511'd0, bus.DataOutValid}, 512'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_latency", 512'(cyc), 512'(e.due));
                    check("rd_data", bus.DataOut, e.data);
                end
            end else begin
                check("rd_hold_stable", bus.DataOut, held);
            end
            if (bus.DataOutReady) in_burst = 1'b0;
        end else begin
            in_burst = 1'b0;
            check("idle_dataout_zero", bus.DataOut, 512'd0);
        end
    end

    task automatic issue_cmd(input logic [2:0] cmd, input logic [27:0] addr);
        bus.Command        = cmd;
        bus.CommandAddress = addr;
        bus.CommandValid   = 1'b1;
        for (int i = 0; i < 40 && !bus.CommandReady; i++) begin
            @(posedge Clock); #1;
        end
        if (!bus.CommandReady) check("cmd_ready_timeout", {511'd0, bus.CommandReady}, 512'd1);
        @(posedge Clock); #1;
        bus.CommandValid = 1'b0;
    endtask

    task automatic do_write(input logic [27:0] addr, input logic [511:0] d);
        issue_cmd(CMD_WR, addr);
        bus.DataIn      = d;
        bus.DataInValid = 1'b1;
        for (int i = 0; i < 10 && !bus.DataInReady; i++) begin
            @(posedge Clock); #1;
        end
        if (!bus.DataInReady) check("data_ready_timeout", {511'd0, bus.DataInReady}, 512'd1);
        @(posedge Clock); #1;
        bus.DataInValid = 1'b0;
    endtask

    task automatic do_read(input logic [27:0] addr, input logic [511:0] exp_data, input bit push);
        exp_t e;
        issue_cmd(CMD_RD, addr);
        e.data = exp_data;
        e.due  = cyc + 8;
        if (push) sb.push_back(e);
    endtask

    initial begin
        logic [511:0] pat_a5;
        logic [511:0] pat_47;
        logic [511:0] pat_hi;
        pat_a5 = {64{8'hA5}};
        pat_47 = {16{32'h4747_1234}};
        pat_hi = {8{64'hDEAD_BEEF_0BAD_F00D}};

        Reset              = 1'b0;
        bus.CommandAddress = '0;
        bus.Command        = CMD_WR;
        bus.CommandValid   = 1'b0;
        bus.DataIn         = '0;
        bus.DataInValid    = 1'b0;
        bus.DataOutReady   = 1'b1;

        // Reset state and release
        repeat (3) @(posedge Clock);
        #1;
        check("rst_cmd_ready", {511'd0, bus.CommandReady}, 512'd0);
        check("rst_din_ready", {511'd0, bus.DataInReady}, 512'd0);
        Reset = 1'b1;
        check("rel_cmd_ready_same_cycle", {511'd0, bus.CommandReady}, 512'd0);
        @(posedge Clock); #1;
        check("rel_cmd_ready", {511'd0, bus.CommandReady}, 512'd1);
        check("rel_read_cnt", 512'(bus.ReadCount), 512'd0);
        check("rel_write_cnt", 512'(bus.WriteCount), 512'd0);
        check("rel_bad_cnt", 512'(bus.BadCmdCount), 512'd0);

        // Stray write data in Idle is ignored
        bus.DataIn      = {16{32'hFFFF_0000}};
        bus.DataInValid = 1'b1;
        @(posedge Clock); #1;
        check("stray_din_ready", {511'd0, bus.DataInReady}, 512'd0);
        check("stray_cmd_ready", {511'd0, bus.CommandReady}, 512'd1);
        check("stray_write_cnt", 512'(bus.WriteCount), 512'd0);
        bus.DataInValid = 1'b0;

        // Write then read back
        do_write(28'h40, pat_a5);
        do_read(28'h40, pat_a5, 1'b1);
        check("wr_rd_read_cnt", 512'(bus.ReadCount), 512'd1);
        check("wr_rd_write_cnt", 512'(bus.WriteCount), 512'd1);

        // Unwritten entry reads zero; consumer stalls for 5 cycles
        issue_cmd(CMD_RD, 28'h80);
        begin
            exp_t e;
            e.data = '0;
            e.due  = cyc + 8;
            sb.push_back(e);
        end
        bus.DataOutReady = 1'b0;
        for (int i = 0; i < 20 && !bus.DataOutValid; i++) begin
            @(posedge Clock); #1;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {511'd0, bus.DataOutValid}, 512'd1);
            check("stall_cmd_ready", {511'd0, bus.CommandReady}, 512'd0);
            @(posedge Clock); #1;
        end
        bus.DataOutReady = 1'b1;
        @(posedge Clock); #1;
        check("stall_release_valid", {511'd0, bus.DataOutValid}, 512'd0);

        // Illegal encoding is consumed and counted
        issue_cmd(CMD_BAD, 28'h40);
        check("bad_cnt", 512'(bus.BadCmdCount), 512'd1);
        check("bad_stays_idle", {511'd0, bus.CommandReady}, 512'd1);
        check("bad_no_read_cnt", 512'(bus.ReadCount), 512'd2);
        do_read(28'h40, pat_a5, 1'b1);

        // Aliasing through low bits and through bits above the index
        do_write(28'h47, pat_47);
        do_read(28'h40, pat_47, 1'b1);
        do_write(28'h2040, pat_hi);
        do_read(28'h40, pat_hi, 1'b1);
        check("alias_read_cnt", 512'(bus.ReadCount), 512'd5);
        check("alias_write_cnt", 512'(bus.WriteCount), 512'd3);

        // Reset during the read wait drops the read and clears written bits
        do_read(28'h40, pat_hi, 1'b0);
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("midrst_cmd_ready", {511'd0, bus.CommandReady}, 512'd0);
        check("midrst_read_cnt", 512'(bus.ReadCount), 512'd0);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b1;
        repeat (12) @(posedge Clock);
        #1;
        do_read(28'h40, 512'd0, 1'b1);
        check("post_rst_read_cnt", 512'(bus.ReadCount), 512'd1);
        check("post_rst_write_cnt", 512'(bus.WriteCount), 512'd0);

        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(posedge Clock); #1;
        end
        repeat (3) @(posedge Clock);
        check("sb_drained", 512'(sb.size()), 512'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
